execute_mc: RTL and testbench

EXECUTE_MC -- requirements
Module: execute_mc

---
 rtl/execute_mc.sv | 317 +++++++++++++++++++++++++++++++
 tb/tb_execute_mc.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_mc.sv
// execute_mc -- multi-cycle execute unit.
//
// Purpose: executes one issued operation at a time. MOV/CLR/ADD/SUB/NOT,
// branches and NOP finish in the transfer cycle, so they sustain one op per
// cycle. MUL runs a radix-2 shift-add over DATA_W cycles. LOAD/STORE hold a
// memory request until the memory acknowledges it.
//
// Handshake: an op transfers on a rising clk edge where in_valid=1 and
// in_ready=1. in_ready is 1 only in IDLE with rst released. While in_ready=0
// the requester keeps in_valid and the op fields stable; nothing is sampled.
// mem_req stays high, with address/data/we stable, up to and including the
// cycle in which mem_ack=1 is sampled. mem_ack is ignored while mem_req=0.
//
// Ports:
//   clk, rst                      clock, synchronous active-low reset
//   in_valid/in_ready             issue handshake
//   op, use_imm, set_flags, imm   operation, operand-B select, flag update
//   dest_reg, src1_reg, src2_reg  register indices of the issued op
//   rd_addr_*/rd_data_*           register-file read port (data sampled at transfer)
//   wb_valid, wb_reg, wb_data     one-cycle register writeback
//   br_taken, br_offset           one-cycle branch redirect
//   flags_out                     NZCV (bit3 N .. bit0 V)
//   busy                          unit not in IDLE
//   mem_*                         memory request / acknowledge
//   stateDbg                      current FSM state (IDLE=0, MUL=1, MEM=2)
module execute_mc #(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16,
  parameter int REG_AW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        op,
  input  logic              use_imm,
  input  logic              set_flags,
  input  logic [IMM_W-1:0]  imm,
  input  logic [REG_AW-1:0] dest_reg,
  input  logic [REG_AW-1:0] src1_reg,
  input  logic [REG_AW-1:0] src2_reg,
  output logic [REG_AW-1:0] rd_addr_dest,
  output logic [REG_AW-1:0] rd_addr_a,
  output logic [REG_AW-1:0] rd_addr_b,
  input  logic [DATA_W-1:0] rd_data_dest,
  input  logic [DATA_W-1:0] rd_data_a,
  input  logic [DATA_W-1:0] rd_data_b,
  output logic              wb_valid,
  output logic [REG_AW-1:0] wb_reg,
  output logic [DATA_W-1:0] wb_data,
  output logic              br_taken,
  output logic [IMM_W-1:0]  br_offset,
  output logic [3:0]        flags_out,
  output logic              busy,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        stateDbg
);

  localparam logic [3:0] OP_MOV   = 4'd0;
  localparam logic [3:0] OP_CLR   = 4'd1;
  localparam logic [3:0] OP_ADD   = 4'd2;
  localparam logic [3:0] OP_SUB   = 4'd3;
  localparam logic [3:0] OP_NOT   = 4'd4;
  localparam logic [3:0] OP_MUL   = 4'd5;
  localparam logic [3:0] OP_LOAD  = 4'd6;
  localparam logic [3:0] OP_STORE = 4'd7;
  localparam logic [3:0] OP_BEQ   = 4'd8;
  localparam logic [3:0] OP_BNE   = 4'd9;
  localparam logic [3:0] OP_BMI   = 4'd10;
  localparam logic [3:0] OP_BPL   = 4'd11;
  localparam logic [3:0] OP_BCS   = 4'd12;
  localparam logic [3:0] OP_BVS   = 4'd13;
  localparam logic [3:0] OP_B     = 4'd14;

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    MEM  = 2'd2
  } state_t;

  state_t state;
  state_t stateNext;

  logic              fire;
  logic [DATA_W-1:0] immExt;
  logic [DATA_W-1:0] opB;
  logic [DATA_W:0]   sumExt;
  logic [DATA_W:0]   diffExt;
  logic [3:0]        addFlags;
  logic [3:0]        subFlags;
  logic              brCond;
  logic [DATA_W-1:0] memAddrCalc;
  logic [DATA_W-1:0] accNext;

  logic [3:0]        flagsQ;
  logic [REG_AW-1:0] destQ;
  logic [REG_AW-1:0] src1Q;
  logic [REG_AW-1:0] src2Q;
  logic [DATA_W-1:0] mcand;
  logic [DATA_W-1:0] mplr;
  logic [DATA_W-1:0] acc;
  logic [CNT_W-1:0]  mulCnt;
  logic              mulSetFlags;
  logic              isLoad;

  // ---------------- operand / flag datapath ----------------
  always_comb begin
    immExt      = DATA_W'($signed(imm));
    opB         = use_imm ? immExt : rd_data_b;
    sumExt      = {1'b0, rd_data_a} + {1'b0, opB};
    diffExt     = {1'b0, rd_data_a} - {1'b0, opB};
    memAddrCalc = rd_data_a + immExt;
    accNext     = acc + (mplr[0] ? mcand : '0);
  end

  // Carry for SUB is "no borrow": the extra bit of diffExt is the borrow.
  always_comb begin
    addFlags[3] = sumExt[DATA_W-1];
    addFlags[2] = (sumExt[DATA_W-1:0] == '0);
    addFlags[1] = sumExt[DATA_W];
    addFlags[0] = (rd_data_a[DATA_W-1] == opB[DATA_W-1]) &&
                  (sumExt[DATA_W-1] != rd_data_a[DATA_W-1]);
    subFlags[3] = diffExt[DATA_W-1];
    subFlags[2] = (diffExt[DATA_W-1:0] == '0);
    subFlags[1] = ~diffExt[DATA_W];
    subFlags[0] = (rd_data_a[DATA_W-1] != opB[DATA_W-1]) &&
                  (diffExt[DATA_W-1] != rd_data_a[DATA_W-1]);
  end

  // Branches read the flag register directly, so a flag-setting op issued
  // in the previous cycle is already visible here.
  always_comb begin
    brCond = 1'b0;
    case (op)
      OP_BEQ:  brCond = flagsQ[2];
      OP_BNE:  brCond = ~flagsQ[2];
      OP_BMI:  brCond = flagsQ[3];
      OP_BPL:  brCond = ~flagsQ[3];
      OP_BCS:  brCond = flagsQ[1];
      OP_BVS:  brCond = flagsQ[0];
      OP_B:    brCond = 1'b1;
      default: brCond = 1'b0;
    endcase
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    fire      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = rst;
        fire     = in_valid & rst;
        if (fire) begin
          if (op == OP_MUL) begin
            stateNext = MUL;
          end else if ((op == OP_LOAD) || (op == OP_STORE)) begin
            stateNext = MEM;
          end
        end
      end
      MUL: begin
        busy = 1'b1;
        if (mulCnt == MUL_LAST) begin
          stateNext = IDLE;
        end
      end
      MEM: begin
        busy = 1'b1;
        if (mem_ack) begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  assign stateDbg     = state;
  assign flags_out    = flagsQ;
  assign rd_addr_dest = (state == IDLE) ? dest_reg : destQ;
  assign rd_addr_a    = (state == IDLE) ? src1_reg : src1Q;
  assign rd_addr_b    = (state == IDLE) ? src2_reg : src2Q;

  // ---------------- sequential datapath ----------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      flagsQ      <= '0;
      wb_valid    <= 1'b0;
      wb_reg      <= '0;
      wb_data     <= '0;
      br_taken    <= 1'b0;
      br_offset   <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      destQ       <= '0;
      src1Q       <= '0;
      src2Q       <= '0;
      mcand       <= '0;
      mplr        <= '0;
      acc         <= '0;
      mulCnt      <= '0;
      mulSetFlags <= 1'b0;
      isLoad      <= 1'b0;
    end else begin
      // Writeback and redirect are single-cycle pulses.
      wb_valid <= 1'b0;
      br_taken <= 1'b0;
      case (state)
        IDLE: begin
          if (fire) begin
            destQ <= dest_reg;
            src1Q <= src1_reg;
            src2Q <= src2_reg;
            case (op)
              OP_MOV: begin
                wb_valid <= 1'b1;
                wb_reg   <= dest_reg;
                wb_data  <= opB;
              end
              OP_CLR: begin
                wb_valid <= 1'b1;
                wb_reg   <= dest_reg;
                wb_data  <= '0;
              end
              OP_ADD: begin
                wb_valid <= 1'b1;
                wb_reg   <= dest_reg;
                wb_data  <= sumExt[DATA_W-1:0];
                if (set_flags) flagsQ <= addFlags;
              end
              OP_SUB: begin
                wb_valid <= 1'b1;
                wb_reg   <= dest_reg;
                wb_data  <= diffExt[DATA_W-1:0];
                if (set_flags) flagsQ <= subFlags;
              end
              OP_NOT: begin
                wb_valid <= 1'b1;
                wb_reg   <= dest_reg;
                wb_data  <= ~rd_data_a;
              end
              OP_MUL: begin
                mcand       <= rd_data_a;
                mplr        <= opB;
                acc         <= '0;
                mulCnt      <= '0;
                mulSetFlags <= set_flags;
              end
              OP_LOAD, OP_STORE: begin
                mem_req   <= 1'b1;
                mem_we    <= (op == OP_STORE);
                mem_addr  <= memAddrCalc;
                mem_wdata <= rd_data_dest;
                isLoad    <= (op == OP_LOAD);
              end
              OP_BEQ, OP_BNE, OP_BMI, OP_BPL, OP_BCS, OP_BVS, OP_B: begin
                if (brCond) begin
                  br_taken  <= 1'b1;
                  br_offset <= imm;
                end
              end
              default: ;  // NOP
            endcase
          end
        end
        MUL: begin
          acc    <= accNext;
          mcand  <= mcand << 1;
          mplr   <= mplr >> 1;
          mulCnt <= mulCnt + 1'b1;
          if (mulCnt == MUL_LAST) begin
            wb_valid <= 1'b1;
            wb_reg   <= destQ;
            wb_data  <= accNext;
            // MUL only touches N and Z; C and V carry over.
            if (mulSetFlags) begin
              flagsQ <= {accNext[DATA_W-1], (accNext == '0), flagsQ[1:0]};
            end
          end
        end
        MEM: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (isLoad) begin
              wb_valid <= 1'b1;
              wb_reg   <= destQ;
              wb_data  <= mem_rdata;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_execute_mc.sv
module tb_execute_mc;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // ---------------- 32-bit instance signals ----------------
  logic        in_valid, in_ready, use_imm, set_flags;
  logic [3:0]  op;
  logic [15:0] imm;
  logic [3:0]  dest_reg, src1_reg, src2_reg;
  logic [3:0]  rd_addr_dest, rd_addr_a, rd_addr_b;
  logic [31:0] rd_data_dest, rd_data_a, rd_data_b;
  logic        wb_valid;
  logic [3:0]  wb_reg;
  logic [31:0] wb_data;
  logic        br_taken;
  logic [15:0] br_offset;
  logic [3:0]  flags_out;
  logic        busy, mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  state_dbg;

  // ---------------- 16-bit instance signals ----------------
  logic        in_valid_16, in_ready_16, use_imm_16, set_flags_16;
  logic [3:0]  op_16;
  logic [7:0]  imm_16;
  logic [3:0]  dest_reg_16;
  logic [3:0]  rd_addr_dest_16, rd_addr_a_16, rd_addr_b_16;
  logic [15:0] rd_data_dest_16, rd_data_a_16, rd_data_b_16;
  logic        wb_valid_16;
  logic [3:0]  wb_reg_16;
  logic [15:0] wb_data_16;
  logic        br_taken_16;
  logic [7:0]  br_offset_16;
  logic [3:0]  flags_out_16;
  logic        busy_16, mem_req_16, mem_we_16;
  logic [15:0] mem_addr_16, mem_wdata_16;
  logic [1:0]  state_dbg_16;

  execute_mc #(.DATA_W(32), .IMM_W(16), .REG_AW(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .use_imm(use_imm), .set_flags(set_flags), .imm(imm),
    .dest_reg(dest_reg), .src1_reg(src1_reg), .src2_reg(src2_reg),
    .rd_addr_dest(rd_addr_dest), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_dest(rd_data_dest), .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
    .br_taken(br_taken), .br_offset(br_offset), .flags_out(flags_out),
    .busy(busy), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .stateDbg(state_dbg)
  );

  execute_mc #(.DATA_W(16), .IMM_W(8), .REG_AW(4)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid_16), .in_ready(in_ready_16),
    .op(op_16), .use_imm(use_imm_16), .set_flags(set_flags_16), .imm(imm_16),
    .dest_reg(dest_reg_16), .src1_reg(4'd1), .src2_reg(4'd2),
    .rd_addr_dest(rd_addr_dest_16), .rd_addr_a(rd_addr_a_16), .rd_addr_b(rd_addr_b_16),
    .rd_data_dest(rd_data_dest_16), .rd_data_a(rd_data_a_16), .rd_data_b(rd_data_b_16),
    .wb_valid(wb_valid_16), .wb_reg(wb_reg_16), .wb_data(wb_data_16),
    .br_taken(br_taken_16), .br_offset(br_offset_16), .flags_out(flags_out_16),
    .busy(busy_16), .mem_req(mem_req_16), .mem_we(mem_we_16), .mem_addr(mem_addr_16),
    .mem_wdata(mem_wdata_16), .mem_ack(1'b0), .mem_rdata(16'h0000),
    .stateDbg(state_dbg_16)
  );

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] o, input logic ui, input logic sf,
                       input logic [15:0] im, input logic [3:0] d,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] dd);
    in_valid = 1'b1; op = o; use_imm = ui; set_flags = sf; imm = im;
    dest_reg = d; src1_reg = d + 4'd1; src2_reg = d + 4'd2;
    rd_data_a = a; rd_data_b = b; rd_data_dest = dd;
  endtask

  task automatic idle();
    in_valid = 1'b0; op = 4'd15; set_flags = 1'b0;
  endtask

  task automatic drive16(input logic [3:0] o, input logic ui, input logic sf,
                         input logic [7:0] im, input logic [3:0] d,
                         input logic [15:0] a, input logic [15:0] b);
    in_valid_16 = 1'b1; op_16 = o; use_imm_16 = ui; set_flags_16 = sf;
    imm_16 = im; dest_reg_16 = d; rd_data_a_16 = a; rd_data_b_16 = b;
    rd_data_dest_16 = 16'h0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b0;
    idle();
    tick();
    tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    checks++; if (flags_out !== 4'b0000) begin errors++; $display("FAIL rst_flags: got %b want 0000", flags_out); end
    checks++; if ({wb_valid, br_taken, mem_req, mem_we, busy} !== 5'b0) begin errors++; $display("FAIL rst_ctrl: got %b want 00000", {wb_valid, br_taken, mem_req, mem_we, busy}); end
    checks++; if ({wb_data, mem_addr, mem_wdata} !== 96'h0) begin errors++; $display("FAIL rst_data: got %h want 0", {wb_data, mem_addr, mem_wdata}); end
    checks++; if (flags_out_16 !== 4'b0000) begin errors++; $display("FAIL rst_flags16: got %b want 0000", flags_out_16); end
    rst = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b want 1", in_ready); end
    tick();
  endtask

  task automatic test_add_flags();
    drive(4'd2, 1'b1, 1'b1, 16'h0001, 4'd3, 32'h7FFF_FFFF, 32'h0, 32'h0);
    tick();
    drive(4'd10, 1'b0, 1'b0, 16'h0040, 4'd0, 32'h0, 32'h0, 32'h0);  // BMI
    checks++; if (wb_valid !== 1'b1 || wb_reg !== 4'd3) begin errors++; $display("FAIL add_wb: got v=%b r=%0d want v=1 r=3", wb_valid, wb_reg); end
    checks++; if (wb_data !== 32'h8000_0000) begin errors++; $display("FAIL add_data: got %h want 80000000", wb_data); end
    checks++; if (flags_out !== 4'b1001) begin errors++; $display("FAIL add_flags: got %b want 1001", flags_out); end
    tick();
    idle();
    checks++; if (br_taken !== 1'b1 || br_offset !== 16'h0040) begin errors++; $display("FAIL bmi_taken: got t=%b off=%h want t=1 off=0040", br_taken, br_offset); end
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL add_wb_pulse: got %b want 0", wb_valid); end
    tick();
    checks++; if (br_taken !== 1'b0) begin errors++; $display("FAIL bmi_pulse: got %b want 0", br_taken); end
  endtask

  task automatic test_sub_branch();
    drive(4'd3, 1'b0, 1'b1, 16'h0000, 4'd4, 32'd5, 32'd5, 32'h0);
    tick();
    drive(4'd8, 1'b0, 1'b0, 16'h0010, 4'd0, 32'h0, 32'h0, 32'h0);  // BEQ
    checks++; if (wb_valid !== 1'b1 || wb_data !== 32'h0) begin errors++; $display("FAIL sub_wb: got v=%b d=%h want v=1 d=0", wb_valid, wb_data); end
    checks++; if (flags_out !== 4'b0110) begin errors++; $display("FAIL sub_flags: got %b want 0110", flags_out); end
    tick();
    drive(4'd9, 1'b0, 1'b0, 16'h0020, 4'd0, 32'h0, 32'h0, 32'h0);  // BNE
    checks++; if (br_taken !== 1'b1 || br_offset !== 16'h0010) begin errors++; $display("FAIL beq_taken: got t=%b off=%h want t=1 off=0010", br_taken, br_offset); end
    tick();
    drive(4'd12, 1'b0, 1'b0, 16'h0030, 4'd0, 32'h0, 32'h0, 32'h0); // BCS
    checks++; if (br_taken !== 1'b0) begin errors++; $display("FAIL bne_not_taken: got %b want 0", br_taken); end
    tick();
    drive(4'd13, 1'b0, 1'b0, 16'h0050, 4'd0, 32'h0, 32'h0, 32'h0); // BVS
    checks++; if (br_taken !== 1'b1 || br_offset !== 16'h0030) begin errors++; $display("FAIL bcs_taken: got t=%b off=%h want t=1 off=0030", br_taken, br_offset); end
    tick();
    idle();
    checks++; if (br_taken !== 1'b0) begin errors++; $display("FAIL bvs_not_taken: got %b want 0", br_taken); end
    checks++; if (flags_out !== 4'b0110) begin errors++; $display("FAIL branch_keeps_flags: got %b want 0110", flags_out); end
  endtask

  task automatic test_back_to_back();
    drive(4'd0, 1'b1, 1'b1, 16'hFF80, 4'd1, 32'h0, 32'h0, 32'h0);          // MOV imm
    tick();
    drive(4'd1, 1'b0, 1'b1, 16'h0000, 4'd2, 32'h0, 32'h0, 32'h0);          // CLR
    checks++; if (wb_valid !== 1'b1 || wb_reg !== 4'd1 || wb_data !== 32'hFFFF_FF80) begin errors++; $display("FAIL mov: got v=%b r=%0d d=%h want 1 1 ffffff80", wb_valid, wb_reg, wb_data); end
    tick();
    drive(4'd4, 1'b0, 1'b0, 16'h0000, 4'd5, 32'h0F0F_0F0F, 32'h0, 32'h0);  // NOT
    checks++; if (wb_valid !== 1'b1 || wb_reg !== 4'd2 || wb_data !== 32'h0) begin errors++; $display("FAIL clr: got v=%b r=%0d d=%h want 1 2 0", wb_valid, wb_reg, wb_data); end
    tick();
    drive(4'd2, 1'b0, 1'b0, 16'h0000, 4'd6, 32'hFFFF_FFFF, 32'd2, 32'h0);  // ADD no flags
    checks++; if (wb_valid !== 1'b1 || wb_reg !== 4'd5 || wb_data !== 32'hF0F0_F0F0) begin errors++; $display("FAIL not: got v=%b r=%0d d=%h want 1 5 f0f0f0f0", wb_valid, wb_reg, wb_data); end
    tick();
    drive(4'd3, 1'b0, 1'b0, 16'h0000, 4'd7, 32'd3, 32'd5, 32'h0);          // SUB no flags
    checks++; if (wb_valid !== 1'b1 || wb_reg !== 4'd6 || wb_data !== 32'h1) begin errors++; $display("FAIL add_wrap: got v=%b r=%0d d=%h want 1 6 1", wb_valid, wb_reg, wb_data); end
    tick();
    idle();
    checks++; if (wb_valid !== 1'b1 || wb_reg !== 4'd7 || wb_data !== 32'hFFFF_FFFE) begin errors++; $display("FAIL sub_neg: got v=%b r=%0d d=%h want 1 7 fffffffe", wb_valid, wb_reg, wb_data); end
    checks++; if (flags_out !== 4'b0110) begin errors++; $display("FAIL b2b_flags_kept: got %b want 0110", flags_out); end
    tick();
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL b2b_end: got %b want 0", wb_valid); end
  endtask

  task automatic test_mul();
    int n;
    int bad;
    drive(4'd5, 1'b0, 1'b1, 16'h0000, 4'd8, 32'h0000_1234, 32'h10, 32'h0);
    tick();
    // Requester holds the next op while the unit is busy.
    drive(4'd0, 1'b1, 1'b0, 16'h0055, 4'd9, 32'h0, 32'h0, 32'h0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mul_busy: got %b want 1", busy); end
    n = 0;
    bad = 0;
    while (in_ready !== 1'b1 && n < 200) begin
      if (wb_valid !== 1'b0) bad++;
      tick();
      n++;
    end
    checks++; if (n != 32) begin errors++; $display("FAIL mul_latency: got %0d cycles not ready want 32", n); end
    checks++; if (bad != 0) begin errors++; $display("FAIL mul_early_wb: got %0d early writebacks want 0", bad); end
    checks++; if (wb_valid !== 1'b1 || wb_reg !== 4'd8 || wb_data !== 32'h0001_2340) begin errors++; $display("FAIL mul_result: got v=%b r=%0d d=%h want 1 8 00012340", wb_valid, wb_reg, wb_data); end
    checks++; if (flags_out !== 4'b0010) begin errors++; $display("FAIL mul_flags: got %b want 0010", flags_out); end
    tick();
    idle();
    checks++; if (wb_valid !== 1'b1 || wb_reg !== 4'd9 || wb_data !== 32'h55) begin errors++; $display("FAIL held_op: got v=%b r=%0d d=%h want 1 9 55", wb_valid, wb_reg, wb_data); end
    tick();
  endtask

  task automatic test_load();
    idle();
    mem_ack = 1'b1;
    mem_rdata = 32'h1111_1111;
    tick();
    mem_ack = 1'b0;
    checks++; if (mem_req !== 1'b0 || wb_valid !== 1'b0) begin errors++; $display("FAIL stray_ack: got req=%b wb=%b want 0 0", mem_req, wb_valid); end
    drive(4'd6, 1'b0, 1'b0, 16'hFFFC, 4'd10, 32'h100, 32'h0, 32'h0);
    tick();
    idle();
    checks++; if (mem_addr !== 32'h0000_00FC || mem_we !== 1'b0) begin errors++; $display("FAIL load_addr: got a=%h we=%b want 000000fc 0", mem_addr, mem_we); end
    for (int i = 1; i <= 3; i++) begin
      checks++; if (mem_req !== 1'b1 || wb_valid !== 1'b0) begin errors++; $display("FAIL load_wait%0d: got req=%b wb=%b want 1 0", i, mem_req, wb_valid); end
      if (i == 3) begin
        mem_ack = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
      end
      tick();
    end
    mem_ack = 1'b0;
    mem_rdata = 32'h0;
    checks++; if (mem_req !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL load_done: got req=%b rdy=%b want 0 1", mem_req, in_ready); end
    checks++; if (wb_valid !== 1'b1 || wb_reg !== 4'd10 || wb_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL load_wb: got v=%b r=%0d d=%h want 1 10 deadbeef", wb_valid, wb_reg, wb_data); end
    checks++; if (flags_out !== 4'b0010) begin errors++; $display("FAIL load_flags: got %b want 0010", flags_out); end
    tick();
  endtask

  task automatic test_store_reset();
    drive(4'd7, 1'b0, 1'b0, 16'h0008, 4'd11, 32'h200, 32'h0, 32'hCAFE_F00D);
    tick();
    idle();
    checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1) begin errors++; $display("FAIL store_req: got req=%b we=%b want 1 1", mem_req, mem_we); end
    checks++; if (mem_addr !== 32'h208 || mem_wdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL store_bus: got a=%h d=%h want 00000208 cafef00d", mem_addr, mem_wdata); end
    tick();
    rst = 1'b0;
    tick();
    checks++; if ({mem_req, mem_we, busy, wb_valid} !== 4'b0) begin errors++; $display("FAIL store_abort: got %b want 0000", {mem_req, mem_we, busy, wb_valid}); end
    checks++; if (flags_out !== 4'b0000 || in_ready !== 1'b0) begin errors++; $display("FAIL store_rst_state: got f=%b rdy=%b want 0000 0", flags_out, in_ready); end
    rst = 1'b1;
    mem_ack = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL store_release: got %b want 1", in_ready); end
    tick();
    mem_ack = 1'b0;
    checks++; if (wb_valid !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL store_no_wb: got wb=%b req=%b want 0 0", wb_valid, mem_req); end
  endtask

  task automatic test_scaled16();
    int n;
    drive16(4'd2, 1'b1, 1'b1, 8'h01, 4'd3, 16'h7FFF, 16'h0);
    tick();
    drive16(4'd10, 1'b0, 1'b0, 8'h12, 4'd0, 16'h0, 16'h0);           // BMI
    checks++; if (wb_valid_16 !== 1'b1 || wb_data_16 !== 16'h8000) begin errors++; $display("FAIL add16: got v=%b d=%h want 1 8000", wb_valid_16, wb_data_16); end
    checks++; if (flags_out_16 !== 4'b1001) begin errors++; $display("FAIL add16_flags: got %b want 1001", flags_out_16); end
    tick();
    drive16(4'd5, 1'b0, 1'b1, 8'h00, 4'd5, 16'h1234, 16'h0010);      // MUL
    checks++; if (br_taken_16 !== 1'b1 || br_offset_16 !== 8'h12) begin errors++; $display("FAIL bmi16: got t=%b off=%h want 1 12", br_taken_16, br_offset_16); end
    tick();
    in_valid_16 = 1'b0;
    n = 0;
    while (in_ready_16 !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    checks++; if (n != 16) begin errors++; $display("FAIL mul16_latency: got %0d want 16", n); end
    checks++; if (wb_valid_16 !== 1'b1 || wb_reg_16 !== 4'd5 || wb_data_16 !== 16'h2340) begin errors++; $display("FAIL mul16_result: got v=%b r=%0d d=%h want 1 5 2340", wb_valid_16, wb_reg_16, wb_data_16); end
    checks++; if (flags_out_16 !== 4'b0001) begin errors++; $display("FAIL mul16_flags: got %b want 0001", flags_out_16); end
    tick();
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    in_valid = 1'b0; op = 4'd15; use_imm = 1'b0; set_flags = 1'b0; imm = '0;
    dest_reg = '0; src1_reg = '0; src2_reg = '0;
    rd_data_dest = '0; rd_data_a = '0; rd_data_b = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    in_valid_16 = 1'b0; op_16 = 4'd15; use_imm_16 = 1'b0; set_flags_16 = 1'b0;
    imm_16 = '0; dest_reg_16 = '0;
    rd_data_dest_16 = '0; rd_data_a_16 = '0; rd_data_b_16 = '0;

    test_reset();
    test_add_flags();
    test_sub_branch();
    test_back_to_back();
    test_mul();
    test_load();
    test_store_reset();
    test_scaled16();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
